// File: rtl/cdb_scheduler_pkg.sv
// Shared encodings and defaults for the CDB result-bus scheduler.
// Unit IDs, one-hot CDB owner codes, reservation slot type, latencies.
package cdb_scheduler_pkg;

   localparam int LAT_MULT_DEF = 3;
   localparam int LAT_DIV_DEF  = 6;

   typedef enum logic [1:0] {
      U_INT  = 2'd0,
      U_LS   = 2'd1,
      U_MULT = 2'd2,
      U_DIV  = 2'd3
   } unit_e;

   // cdb_sel bit order is {int,div,mult,ls}
   localparam logic [3:0] SEL_INT  = 4'b1000;
   localparam logic [3:0] SEL_DIV  = 4'b0100;
   localparam logic [3:0] SEL_MULT = 4'b0010;
   localparam logic [3:0] SEL_LS   = 4'b0001;

   typedef struct packed {
      logic  vld;
      unit_e id;
   } slot_t;

   typedef enum logic {
      DIV_IDLE = 1'b0,
      DIV_BUSY = 1'b1
   } div_st_e;

   function automatic logic [3:0] unit_sel(input slot_t s);
      logic [3:0] r;
      r = 4'b0000;
      if (s.vld) begin
         unique case (s.id)
            U_INT:   r = SEL_INT;
            U_LS:    r = SEL_LS;
            U_MULT:  r = SEL_MULT;
            U_DIV:   r = SEL_DIV;
            default: r = 4'b0000;
         endcase
      end
      return r;
   endfunction

endpackage

// File: rtl/cdb_slot_ring.sv
// CDB reservation ring: entry k owns the CDB cycle k+1 ahead.
// Reservations merge at their offset; the ring shifts one step per cycle.
module cdb_slot_ring
   import cdb_scheduler_pkg::*;
#(
   parameter int DEPTH = LAT_DIV_DEF
) (
   input  logic                    clk,
   input  logic                    reset,
   input  slot_t [DEPTH-1:0]       rsv_i,
   output logic  [DEPTH-1:0]       occ_o,
   output slot_t                   head_o
);

   slot_t [DEPTH-1:0] slot_q;
   slot_t [DEPTH-1:0] slot_d;
   slot_t [DEPTH-1:0] cmb;

   // Merge new reservations, then shift toward the CDB end.
   always_comb begin
      cmb    = slot_q;
      slot_d = '0;
      for (int k = 0; k < DEPTH; k++) begin
         if (rsv_i[k].vld) cmb[k] = rsv_i[k];
         occ_o[k] = slot_q[k].vld;
      end
      for (int k = 0; k < DEPTH-1; k++) begin
         slot_d[k] = cmb[k+1];
      end
      head_o = cmb[0];
   end

   // Reservation storage; reset drops everything in flight.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) slot_q <= '0;
      else        slot_q <= slot_d;
   end

endmodule

// File: rtl/cdb_scheduler.sv
// Issue/CDB scheduler: grants int/ls/mult/div so no two results collide.
// Optional macro CDB_SCHED_RR_EN enables int/ls round-robin.
module cdb_scheduler
   import cdb_scheduler_pkg::*;
#(
   parameter int LAT_MULT = LAT_MULT_DEF,
   parameter int LAT_DIV  = LAT_DIV_DEF
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       req_int,
   input  logic       req_ls,
   input  logic       req_mult,
   input  logic       req_div,
   output logic       gnt_int,
   output logic       gnt_ls,
   output logic       gnt_mult,
   output logic       gnt_div,
   output logic [3:0] cdb_sel,
   output logic       cdb_valid,
   output logic       div_busy
);

   localparam logic [LAT_DIV-1:0] M_ONE  = LAT_DIV'(1);
   localparam logic [LAT_DIV-1:0] M_MULT = M_ONE << (LAT_MULT-1);
   localparam logic [LAT_DIV-1:0] M_DIV  = M_ONE << (LAT_DIV-1);
   localparam logic [3:0]         CNT_LD = 4'(LAT_DIV-1);

   slot_t [LAT_DIV-1:0] rsv;
   logic  [LAT_DIV-1:0] occ;
   slot_t               head;

   div_st_e    st_q, st_d;
   logic [3:0] cnt_q, cnt_d;
   logic [3:0] cdb_sel_q;
   logic       cdb_valid_q;
   logic       free1, free_m, free_d;
   logic       ls_first;

   assign free1  = ~|(occ & M_ONE);
   assign free_m = ~|(occ & M_MULT);
   assign free_d = ~|(occ & M_DIV);

`ifdef CDB_SCHED_RR_EN
   logic rr_q;

   // Pointer flips only when int and ls contended and one won.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         rr_q <= 1'b0;
      else if (req_int && req_ls && (gnt_int || gnt_ls))
         rr_q <= ~rr_q;
   end

   assign ls_first = rr_q;
`else
   assign ls_first = 1'b0;
`endif

   // Grants: each unit needs its target CDB slot free; div also needs IDLE.
   always_comb begin
      gnt_div  = reset & req_div & free_d & (st_q == DIV_IDLE);
      gnt_mult = reset & req_mult & free_m;
      gnt_int  = reset & free1 & req_int & ~(req_ls & ls_first);
      gnt_ls   = reset & free1 & req_ls & ~(req_int & ~ls_first);
      rsv = '0;
      if (gnt_int)  rsv[0] = '{vld: 1'b1, id: U_INT};
      if (gnt_ls)   rsv[0] = '{vld: 1'b1, id: U_LS};
      if (gnt_mult) rsv[LAT_MULT-1] = '{vld: 1'b1, id: U_MULT};
      if (gnt_div)  rsv[LAT_DIV-1]  = '{vld: 1'b1, id: U_DIV};
   end

   cdb_slot_ring #(
      .DEPTH (LAT_DIV)
   ) u_ring (
      .clk    (clk),
      .reset  (reset),
      .rsv_i  (rsv),
      .occ_o  (occ),
      .head_o (head)
   );

   // Divider next state: count down the busy period after a grant.
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      unique case (st_q)
         DIV_IDLE: begin
            if (gnt_div) begin
               st_d  = DIV_BUSY;
               cnt_d = CNT_LD;
            end
         end
         DIV_BUSY: begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) st_d = DIV_IDLE;
         end
         default: begin
            st_d  = DIV_IDLE;
            cnt_d = 4'd0;
         end
      endcase
   end

   // Divider state and CDB owner registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st_q        <= DIV_IDLE;
         cnt_q       <= 4'd0;
         cdb_sel_q   <= 4'b0000;
         cdb_valid_q <= 1'b0;
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         cdb_sel_q   <= unit_sel(head);
         cdb_valid_q <= head.vld;
      end
   end

   assign cdb_sel   = cdb_sel_q;
   assign cdb_valid = cdb_valid_q;
   assign div_busy  = (st_q == DIV_BUSY);

endmodule

// File: tb/tb_cdb_scheduler.sv
// Directed bench for cdb_scheduler; vectors are hex digits per cycle.
// Digit bits {int,div,mult,ls}, leftmost digit is cycle 0.
module tb_cdb_scheduler;

   logic       clk;
   logic       reset;
   logic       req_int, req_ls, req_mult, req_div;
   logic       gnt_int, gnt_ls, gnt_mult, gnt_div;
   logic [3:0] cdb_sel;
   logic       cdb_valid;
   logic       div_busy;

   int errors = 0;
   int checks = 0;

   logic [3:0] s_gnt;
   logic [3:0] s_sel;
   logic       s_vld;
   logic       s_busy;

   cdb_scheduler dut (
      .clk       (clk),
      .reset     (reset),
      .req_int   (req_int),
      .req_ls    (req_ls),
      .req_mult  (req_mult),
      .req_div   (req_div),
      .gnt_int   (gnt_int),
      .gnt_ls    (gnt_ls),
      .gnt_mult  (gnt_mult),
      .gnt_div   (gnt_div),
      .cdb_sel   (cdb_sel),
      .cdb_valid (cdb_valid),
      .div_busy  (div_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   // Drive one cycle of requests, sample mid-cycle, advance.
   task automatic step(input logic [3:0] rq);
      req_int  = rq[3];
      req_div  = rq[2];
      req_mult = rq[1];
      req_ls   = rq[0];
      #2;
      s_gnt  = {gnt_int, gnt_div, gnt_mult, gnt_ls};
      s_sel  = cdb_sel;
      s_vld  = cdb_valid;
      s_busy = div_busy;
      @(posedge clk);
      #1;
   endtask

   task automatic flush(input int n);
      for (int i = 0; i < n; i++) step(4'h0);
   endtask

   task automatic run(input string nm, input int n,
                      input logic [63:0] rq, input logic [63:0] eg,
                      input logic [63:0] es, input logic [15:0] eb);
      logic [3:0] d;
      for (int t = 0; t < n; t++) begin
         step(rq[63-4*t -: 4]);
         d = es[63-4*t -: 4];
         check($sformatf("%s t%0d gnt", nm, t), 32'(s_gnt),
               32'(eg[63-4*t -: 4]));
         check($sformatf("%s t%0d sel", nm, t), 32'(s_sel), 32'(d));
         check($sformatf("%s t%0d vld", nm, t), 32'(s_vld),
               32'(d != 4'h0));
         check($sformatf("%s t%0d busy", nm, t), 32'(s_busy),
               32'(eb[15-t]));
      end
   endtask

   initial begin
      reset    = 1'b0;
      req_int  = 1'b0;
      req_ls   = 1'b0;
      req_mult = 1'b0;
      req_div  = 1'b0;
      @(posedge clk);
      #1;

      step(4'hF);
      check("rst gnt", 32'(s_gnt), 32'h0);
      check("rst sel", 32'(s_sel), 32'h0);
      check("rst vld", 32'(s_vld), 32'h0);
      check("rst busy", 32'(s_busy), 32'h0);

      reset = 1'b1;
      flush(2);

      run("int1", 10, 64'h0000_0800_0000_0000, 64'h0000_0800_0000_0000,
          64'h0000_0080_0000_0000, 16'h0000);
      flush(4);

`ifdef CDB_SCHED_RR_EN
      run("rr", 6, 64'h9999_0000_0000_0000, 64'h8181_0000_0000_0000,
          64'h0818_1000_0000_0000, 16'h0000);
`else
      run("fix", 6, 64'h9999_0000_0000_0000, 64'h8888_0000_0000_0000,
          64'h0888_8000_0000_0000, 16'h0000);
`endif
      flush(4);

      run("div", 16, 64'h4444_4444_4444_4440, 64'h4000_0040_0000_4000,
          64'h0000_0040_0000_4000, 16'h7DF7);
      flush(10);

      run("mdv", 10, 64'h6222_2200_0000_0000, 64'h6220_2200_0000_0000,
          64'h0002_2242_2000_0000, 16'h7C00);
      flush(4);

      run("mint", 10, 64'h0020_8800_0000_0000, 64'h0020_0800_0000_0000,
          64'h0000_0280_0000_0000, 16'h0000);
      flush(4);

      run("tri", 8, 64'hE000_0000_0000_0000, 64'hE000_0000_0000_0000,
          64'h0802_0040_0000_0000, 16'h7C00);
      flush(4);

      step(4'h4);
      check("mrst t0 gnt", 32'(s_gnt), 32'h4);
      step(4'h0);
      step(4'h0);
      check("mrst t2 busy", 32'(s_busy), 32'h1);
      reset = 1'b0;
      step(4'h4);
      check("mrst t3 gnt", 32'(s_gnt), 32'h0);
      check("mrst t3 busy", 32'(s_busy), 32'h0);
      check("mrst t3 vld", 32'(s_vld), 32'h0);
      reset = 1'b1;
      step(4'h4);
      check("mrst t4 gnt", 32'(s_gnt), 32'h4);
      for (int t = 5; t <= 8; t++) begin
         step(4'h0);
         check($sformatf("mrst t%0d vld", t), 32'(s_vld), 32'h0);
         check($sformatf("mrst t%0d sel", t), 32'(s_sel), 32'h0);
      end
      step(4'h0);
      step(4'h0);
      check("mrst t10 sel", 32'(s_sel), 32'h4);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
